// File: rtl/roi_capture_buffer_pkg.sv
// Shared definitions for the ROI capture buffer: FSM encoding,
// default frame geometry and a width helper for address/counter sizing.
package roi_capture_buffer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CAPTURE = 2'd1,
      ST_READY   = 2'd2
   } roi_state_e;

   localparam int unsigned DEF_IMG_W = 320;
   localparam int unsigned DEF_IMG_H = 240;

   // Bits needed to address n items; never returns less than 1 so that
   // degenerate sizes still produce legal vector declarations.
   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      r = 0;
      while ((32'd1 << r) < n) r++;
      return (r == 0) ? 1 : r;
   endfunction

endpackage

// File: rtl/roi_capture_buffer_frame_ram.sv
// Frame store: one write port fed by the capture counters, one registered
// read port for the classifier. No reset so it maps onto block RAM.
// A read and write to the same address in one cycle returns the old word.
module roi_capture_buffer_frame_ram #(
   parameter int unsigned DEPTH = 76800,
   parameter int unsigned AW    = 17,
   parameter int unsigned PIX_W = 1
) (
   input  logic             iCLK,
   input  logic             iWe,
   input  logic [AW-1:0]    iWaddr,
   input  logic [PIX_W-1:0] iWdata,
   input  logic             iRe,
   input  logic [AW-1:0]    iRaddr,
   output logic [PIX_W-1:0] oRdata
);

   logic [PIX_W-1:0] mem_q [DEPTH];
   logic [PIX_W-1:0] rdata_q;

   // Synchronous pixel write.
   always_ff @(posedge iCLK) begin
      if (iWe) mem_q[iWaddr] <= iWdata;
   end

   // Registered read; samples the array before this edge's write lands.
   always_ff @(posedge iCLK) begin
      if (iRe) rdata_q <= mem_q[iRaddr];
   end

   assign oRdata = rdata_q;

endmodule

// File: rtl/roi_capture_buffer.sv
// ROI capture buffer: captures one frame from the pixel stream, counts rows
// touched, tracks the foreground bounding box and serves random reads.
// Valid/ready: the pixel stream has no back-pressure; a pixel is taken on
// every edge where iDVAL is high and the FSM is in CAPTURE without iStart.
// Reads are always accepted; oRd_valid follows iRd_en by exactly one edge.
module roi_capture_buffer
   import roi_capture_buffer_pkg::*;
#(
   parameter int unsigned IMG_W  = DEF_IMG_W,
   parameter int unsigned IMG_H  = DEF_IMG_H,
   parameter int unsigned PIX_W  = 1,
   parameter int unsigned THRESH = 0
) (
   input  logic                          iCLK,
   input  logic                          iRST,
   input  logic                          iStart,
   input  logic                          iDone,
   input  logic [PIX_W-1:0]              iDATA,
   input  logic                          iDVAL,
   input  logic                          iRd_en,
   input  logic [clog2(IMG_H)-1:0]       iRd_row,
   input  logic [clog2(IMG_W)-1:0]       iRd_col,
   output logic [PIX_W-1:0]              oRd_data,
   output logic                          oRd_valid,
   output logic                          oBusy,
   output logic                          oDone,
   output logic [clog2(IMG_H+1)-1:0]     oRows,
   output logic [clog2(IMG_W)-1:0]       oX_min,
   output logic [clog2(IMG_W)-1:0]       oX_max,
   output logic [clog2(IMG_H)-1:0]       oY_min,
   output logic [clog2(IMG_H)-1:0]       oY_max,
   output logic                          oBBox_valid,
   output logic                          oOverflow,
   output roi_state_e                    oState
);

   localparam int unsigned RW    = clog2(IMG_H);
   localparam int unsigned CW    = clog2(IMG_W);
   localparam int unsigned NW    = clog2(IMG_H + 1);
   localparam int unsigned DEPTH = IMG_W * IMG_H;
   localparam int unsigned AW    = clog2(DEPTH);

   roi_state_e     state_q, state_d;
   logic [RW-1:0]  row_q, row_d;
   logic [CW-1:0]  col_q, col_d;
   logic [NW-1:0]  rows_q, rows_d;
   logic [CW-1:0]  x_min_q, x_min_d, x_max_q, x_max_d;
   logic [RW-1:0]  y_min_q, y_min_d, y_max_q, y_max_d;
   logic           bbox_valid_q, bbox_valid_d;
   logic           overflow_q, overflow_d;
   logic           done_q, done_d;
   logic           rd_valid_q, rd_in_range_q;

   logic             we, clear, fg, last_px, rd_in_range;
   logic [AW-1:0]    waddr, raddr;
   logic [PIX_W-1:0] ram_rdata;

   assign fg          = 32'(iDATA) > THRESH;
   assign last_px     = (row_q == RW'(IMG_H - 1)) && (col_q == CW'(IMG_W - 1));
   assign waddr       = AW'(32'(row_q) * IMG_W + 32'(col_q));
   assign rd_in_range = (32'(iRd_row) < IMG_H) && (32'(iRd_col) < IMG_W);
   assign raddr       = AW'(32'(iRd_row) * IMG_W + 32'(iRd_col));

   // Next-state, write strobe, counter advance and bounding-box update.
   always_comb begin
      state_d      = state_q;
      row_d        = row_q;
      col_d        = col_q;
      rows_d       = rows_q;
      x_min_d      = x_min_q;
      x_max_d      = x_max_q;
      y_min_d      = y_min_q;
      y_max_d      = y_max_q;
      bbox_valid_d = bbox_valid_q;
      overflow_d   = overflow_q;
      done_d       = 1'b0;
      we           = 1'b0;
      clear        = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (iStart) begin
               state_d = ST_CAPTURE;
               clear   = 1'b1;
            end
         end
         ST_CAPTURE: begin
            if (iStart) begin
               clear = 1'b1;
            end else begin
               if (iDVAL) begin
                  we     = 1'b1;
                  rows_d = NW'(row_q) + NW'(1);
                  if (col_q == CW'(IMG_W - 1)) begin
                     col_d = '0;
                     if (row_q != RW'(IMG_H - 1)) row_d = row_q + RW'(1);
                  end else begin
                     col_d = col_q + CW'(1);
                  end
                  if (fg) begin
                     bbox_valid_d = 1'b1;
                     if (!bbox_valid_q || col_q < x_min_q) x_min_d = col_q;
                     if (!bbox_valid_q || col_q > x_max_q) x_max_d = col_q;
                     if (!bbox_valid_q || row_q < y_min_q) y_min_d = row_q;
                     if (!bbox_valid_q || row_q > y_max_q) y_max_d = row_q;
                  end
               end
               if ((iDVAL && last_px) || iDone) begin
                  state_d = ST_READY;
                  done_d  = 1'b1;
               end
            end
         end
         ST_READY: begin
            if (iStart) begin
               state_d = ST_CAPTURE;
               clear   = 1'b1;
            end else if (iDVAL) begin
               overflow_d = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (clear) begin
         row_d        = '0;
         col_d        = '0;
         rows_d       = '0;
         x_min_d      = '0;
         x_max_d      = '0;
         y_min_d      = '0;
         y_max_d      = '0;
         bbox_valid_d = 1'b0;
         overflow_d   = 1'b0;
      end
   end

   // State and datapath registers; async active-low reset drops any partial frame.
   always_ff @(posedge iCLK or negedge iRST) begin
      if (!iRST) begin
         state_q       <= ST_IDLE;
         row_q         <= '0;
         col_q         <= '0;
         rows_q        <= '0;
         x_min_q       <= '0;
         x_max_q       <= '0;
         y_min_q       <= '0;
         y_max_q       <= '0;
         bbox_valid_q  <= 1'b0;
         overflow_q    <= 1'b0;
         done_q        <= 1'b0;
         rd_valid_q    <= 1'b0;
         rd_in_range_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         row_q         <= row_d;
         col_q         <= col_d;
         rows_q        <= rows_d;
         x_min_q       <= x_min_d;
         x_max_q       <= x_max_d;
         y_min_q       <= y_min_d;
         y_max_q       <= y_max_d;
         bbox_valid_q  <= bbox_valid_d;
         overflow_q    <= overflow_d;
         done_q        <= done_d;
         rd_valid_q    <= iRd_en;
         rd_in_range_q <= iRd_en && rd_in_range;
      end
   end

   roi_capture_buffer_frame_ram #(
      .DEPTH (DEPTH),
      .AW    (AW),
      .PIX_W (PIX_W)
   ) u_ram (
      .iCLK   (iCLK),
      .iWe    (we),
      .iWaddr (waddr),
      .iWdata (iDATA),
      .iRe    (iRd_en && rd_in_range),
      .iRaddr (raddr),
      .oRdata (ram_rdata)
   );

   assign oRd_data    = rd_in_range_q ? ram_rdata : '0;
   assign oRd_valid   = rd_valid_q;
   assign oBusy       = (state_q == ST_CAPTURE);
   assign oDone       = done_q;
   assign oRows       = rows_q;
   assign oX_min      = bbox_valid_q ? x_min_q : '0;
   assign oX_max      = bbox_valid_q ? x_max_q : '0;
   assign oY_min      = bbox_valid_q ? y_min_q : '0;
   assign oY_max      = bbox_valid_q ? y_max_q : '0;
   assign oBBox_valid = bbox_valid_q;
   assign oOverflow   = overflow_q;
   assign oState      = state_q;

endmodule

// File: tb/tb_roi_capture_buffer.sv
// Bench for roi_capture_buffer on an 8x4 frame of 4-bit pixels, plus a
// 5x3 instance whose non-power-of-two geometry allows out-of-range reads.
module tb_roi_capture_buffer;
   import roi_capture_buffer_pkg::*;

   // ---------------- clock / reset ----------------
   logic iCLK = 1'b0;
   logic iRST = 1'b0;
   always #5 iCLK = ~iCLK;

   // ---------------- main DUT (8x4) ----------------
   logic       iStart, iDone, iDVAL, iRd_en;
   logic [3:0] iDATA;
   logic [1:0] iRd_row;
   logic [2:0] iRd_col;
   logic [3:0] oRd_data;
   logic       oRd_valid, oBusy, oDone, oBBox_valid, oOverflow;
   logic [2:0] oRows, oX_min, oX_max;
   logic [1:0] oY_min, oY_max;
   roi_state_e oState;

   roi_capture_buffer #(.IMG_W(8), .IMG_H(4), .PIX_W(4), .THRESH(0)) u_dut (
      .iCLK(iCLK), .iRST(iRST), .iStart(iStart), .iDone(iDone),
      .iDATA(iDATA), .iDVAL(iDVAL), .iRd_en(iRd_en), .iRd_row(iRd_row),
      .iRd_col(iRd_col), .oRd_data(oRd_data), .oRd_valid(oRd_valid),
      .oBusy(oBusy), .oDone(oDone), .oRows(oRows), .oX_min(oX_min),
      .oX_max(oX_max), .oY_min(oY_min), .oY_max(oY_max),
      .oBBox_valid(oBBox_valid), .oOverflow(oOverflow), .oState(oState)
   );

   // ---------------- range-check DUT (5x3) ----------------
   logic       s_start = 1'b0, s_done = 1'b0, s_dval = 1'b0, s_rd_en = 1'b0;
   logic [3:0] s_data = 4'd0;
   logic [1:0] s_rd_row = 2'd0;
   logic [2:0] s_rd_col = 3'd0;
   logic [3:0] s_rd_data;
   logic       s_rd_valid, s_busy, s_done_o, s_bbv, s_ovf;
   logic [1:0] s_rows, s_y_min, s_y_max;
   logic [2:0] s_x_min, s_x_max;
   roi_state_e s_state;

   roi_capture_buffer #(.IMG_W(5), .IMG_H(3), .PIX_W(4), .THRESH(0)) u_dut_small (
      .iCLK(iCLK), .iRST(iRST), .iStart(s_start), .iDone(s_done),
      .iDATA(s_data), .iDVAL(s_dval), .iRd_en(s_rd_en), .iRd_row(s_rd_row),
      .iRd_col(s_rd_col), .oRd_data(s_rd_data), .oRd_valid(s_rd_valid),
      .oBusy(s_busy), .oDone(s_done_o), .oRows(s_rows), .oX_min(s_x_min),
      .oX_max(s_x_max), .oY_min(s_y_min), .oY_max(s_y_max),
      .oBBox_valid(s_bbv), .oOverflow(s_ovf), .oState(s_state)
   );

   // ---------------- check bookkeeping ----------------
   int pass_cnt  = 0;
   int check_cnt = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      check_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // ---------------- read scoreboard ----------------
   logic [3:0] exp_q[$];
   logic [3:0] rd_exp_stage = 4'd0;
   logic [3:0] rd_pop;

   // Expected read data enters the queue on the edge that accepts the request.
   always @(posedge iCLK) begin
      if (iRST && iRd_en) exp_q.push_back(rd_exp_stage);
   end

   // One edge later the result must be present; any valid with nothing pending is spurious.
   always @(negedge iCLK) begin
      if (exp_q.size() != 0) begin
         rd_pop = exp_q.pop_front();
         check("rd_valid", 32'(oRd_valid), 32'd1);
         check("rd_data", 32'(oRd_data), 32'(rd_pop));
      end else if (oRd_valid) begin
         check("rd_spurious", 32'(oRd_valid), 32'd0);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic cyc(input logic st, input logic dn, input logic dv, input logic [3:0] d,
                      input logic re, input logic [1:0] rr, input logic [2:0] rc,
                      input logic [3:0] ex);
      iStart = st; iDone = dn; iDVAL = dv; iDATA = d;
      iRd_en = re; iRd_row = rr; iRd_col = rc; rd_exp_stage = ex;
      @(posedge iCLK); #1;
   endtask

   task automatic idle();
      cyc(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 2'd0, 3'd0, 4'd0);
   endtask

   task automatic px(input logic [3:0] d);
      cyc(1'b0, 1'b0, 1'b1, d, 1'b0, 2'd0, 3'd0, 4'd0);
   endtask

   task automatic start();
      cyc(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 2'd0, 3'd0, 4'd0);
   endtask

   task automatic check_bbox(input string tag, input logic v, input logic [2:0] x0,
                             input logic [2:0] x1, input logic [1:0] y0, input logic [1:0] y1);
      check({tag, "_bbv"}, 32'(oBBox_valid), 32'(v));
      check({tag, "_xmin"}, 32'(oX_min), 32'(x0));
      check({tag, "_xmax"}, 32'(oX_max), 32'(x1));
      check({tag, "_ymin"}, 32'(oY_min), 32'(y0));
      check({tag, "_ymax"}, 32'(oY_max), 32'(y1));
   endtask

   // ---------------- readback vectors ----------------
   typedef struct {
      logic [1:0] row;
      logic [2:0] col;
      logic [3:0] exp;
   } rd_vec_t;

   rd_vec_t rd_tab[5];

   logic [3:0] pix_val;

   initial begin
      // frame 1 contents: foreground only at (1,2)=5 and (3,6)=9
      rd_tab[0] = '{row: 2'd1, col: 3'd2, exp: 4'd5};
      rd_tab[1] = '{row: 2'd3, col: 3'd6, exp: 4'd9};
      rd_tab[2] = '{row: 2'd0, col: 3'd0, exp: 4'd0};
      rd_tab[3] = '{row: 2'd3, col: 3'd7, exp: 4'd0};
      rd_tab[4] = '{row: 2'd1, col: 3'd3, exp: 4'd0};

      iStart = 0; iDone = 0; iDVAL = 0; iDATA = 0;
      iRd_en = 0; iRd_row = 0; iRd_col = 0;

      // ---- 1: reset values, iDVAL ignored in IDLE ----
      repeat (2) @(posedge iCLK);
      #1;
      check("rst_state", 32'(oState), 32'(ST_IDLE));
      check("rst_busy", 32'(oBusy), 32'd0);
      check("rst_done", 32'(oDone), 32'd0);
      check("rst_rows", 32'(oRows), 32'd0);
      check("rst_ovf", 32'(oOverflow), 32'd0);
      check("rst_rdv", 32'(oRd_valid), 32'd0);
      check("rst_rdd", 32'(oRd_data), 32'd0);
      check_bbox("rst", 1'b0, 3'd0, 3'd0, 2'd0, 2'd0);
      iRST = 1'b1;
      repeat (3) px(4'hF);
      check("idle_dval_state", 32'(oState), 32'(ST_IDLE));
      check("idle_dval_rows", 32'(oRows), 32'd0);
      check("idle_dval_bbv", 32'(oBBox_valid), 32'd0);
      check("idle_dval_ovf", 32'(oOverflow), 32'd0);

      // ---- 2: full frame ----
      start();
      check("f1_state", 32'(oState), 32'(ST_CAPTURE));
      check("f1_busy", 32'(oBusy), 32'd1);
      for (int i = 0; i < 32; i++) begin
         pix_val = (i == 10) ? 4'd5 : (i == 30) ? 4'd9 : 4'd0;
         px(pix_val);
         if (i == 10) check_bbox("f1_first", 1'b1, 3'd2, 3'd2, 2'd1, 2'd1);
         if (i == 30) check("f1_done_early", 32'(oDone), 32'd0);
      end
      check("f1_done", 32'(oDone), 32'd1);
      check("f1_state_rdy", 32'(oState), 32'(ST_READY));
      check("f1_rows", 32'(oRows), 32'd4);
      check_bbox("f1", 1'b1, 3'd2, 3'd6, 2'd1, 2'd3);
      idle();
      check("f1_done_pulse", 32'(oDone), 32'd0);
      check("f1_busy_rdy", 32'(oBusy), 32'd0);

      for (int k = 0; k < 5; k++)
         cyc(1'b0, 1'b0, 1'b0, 4'd0, 1'b1, rd_tab[k].row, rd_tab[k].col, rd_tab[k].exp);
      idle();

      // ---- 3: iDone coincident with pixel 11 ----
      start();
      check("f2_rows_clr", 32'(oRows), 32'd0);
      check("f2_bbv_clr", 32'(oBBox_valid), 32'd0);
      for (int i = 0; i < 10; i++) px(4'(i));
      cyc(1'b0, 1'b1, 1'b1, 4'd10, 1'b0, 2'd0, 3'd0, 4'd0);
      check("f2_state", 32'(oState), 32'(ST_READY));
      check("f2_done", 32'(oDone), 32'd1);
      check("f2_rows", 32'(oRows), 32'd2);
      check_bbox("f2", 1'b1, 3'd0, 3'd7, 2'd0, 2'd1);
      cyc(1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 2'd1, 3'd2, 4'd10);
      cyc(1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 2'd0, 3'd5, 4'd5);
      cyc(1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 2'd1, 3'd3, 4'd0);
      idle();

      // ---- 4: all-zero partial frame, iDone alone, overflow ----
      start();
      repeat (5) px(4'd0);
      cyc(1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 2'd0, 3'd0, 4'd0);
      check("f3_state", 32'(oState), 32'(ST_READY));
      check("f3_done", 32'(oDone), 32'd1);
      check("f3_rows", 32'(oRows), 32'd1);
      check_bbox("f3", 1'b0, 3'd0, 3'd0, 2'd0, 2'd0);
      repeat (3) px(4'hF);
      check("ovf_set", 32'(oOverflow), 32'd1);
      check("ovf_state", 32'(oState), 32'(ST_READY));
      check("ovf_bbv", 32'(oBBox_valid), 32'd0);
      check("ovf_rows", 32'(oRows), 32'd1);
      start();
      check("ovf_clr", 32'(oOverflow), 32'd0);
      check("ovf_clr_state", 32'(oState), 32'(ST_CAPTURE));
      repeat (2) px(4'd0);
      cyc(1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 2'd0, 3'd0, 4'd0);
      check("prio_state", 32'(oState), 32'(ST_CAPTURE));
      check("prio_done", 32'(oDone), 32'd0);
      check("prio_rows", 32'(oRows), 32'd0);

      // ---- 5: restart mid-frame with a pixel, then a full frame ----
      repeat (5) px(4'd0);
      check("pre_restart_rows", 32'(oRows), 32'd1);
      cyc(1'b1, 1'b0, 1'b1, 4'hF, 1'b0, 2'd0, 3'd0, 4'd0);
      check("restart_rows", 32'(oRows), 32'd0);
      check("restart_bbv", 32'(oBBox_valid), 32'd0);
      check("restart_state", 32'(oState), 32'(ST_CAPTURE));
      for (int i = 0; i < 32; i++) begin
         pix_val = (i / 8 == 2 && i % 8 >= 1 && i % 8 <= 4) ? 4'(i % 8) : 4'd0;
         if (i == 10)
            cyc(1'b0, 1'b0, 1'b1, pix_val, 1'b1, 2'd1, 3'd2, 4'd10);
         else if (i == 17)
            cyc(1'b0, 1'b0, 1'b1, pix_val, 1'b1, 2'd2, 3'd1, 4'd0);
         else
            px(pix_val);
         if (i == 30) check("f4_done_early", 32'(oDone), 32'd0);
      end
      check("f4_done", 32'(oDone), 32'd1);
      check("f4_rows", 32'(oRows), 32'd4);
      check_bbox("f4", 1'b1, 3'd1, 3'd4, 2'd2, 2'd2);
      cyc(1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 2'd2, 3'd1, 4'd1);
      idle();

      // ---- 6: read latency, out-of-range reads, async reset ----
      cyc(1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 2'd2, 3'd3, 4'd3);
      check("lat_valid", 32'(oRd_valid), 32'd1);
      check("lat_data", 32'(oRd_data), 32'd3);
      idle();
      check("lat_valid_drop", 32'(oRd_valid), 32'd0);

      s_rd_en = 1'b1; s_rd_row = 2'd3; s_rd_col = 3'd0;
      @(posedge iCLK); #1;
      check("oor_row_valid", 32'(s_rd_valid), 32'd1);
      check("oor_row_data", 32'(s_rd_data), 32'd0);
      s_rd_row = 2'd0; s_rd_col = 3'd5;
      @(posedge iCLK); #1;
      check("oor_col_valid", 32'(s_rd_valid), 32'd1);
      check("oor_col_data", 32'(s_rd_data), 32'd0);
      s_rd_en = 1'b0;
      @(posedge iCLK); #1;
      check("oor_valid_drop", 32'(s_rd_valid), 32'd0);

      start();
      repeat (3) px(4'd7);
      check("pre_arst_rows", 32'(oRows), 32'd1);
      check("pre_arst_busy", 32'(oBusy), 32'd1);
      #3 iRST = 1'b0;
      #1;
      check("arst_state", 32'(oState), 32'(ST_IDLE));
      check("arst_busy", 32'(oBusy), 32'd0);
      check("arst_rows", 32'(oRows), 32'd0);
      check("arst_bbv", 32'(oBBox_valid), 32'd0);
      @(posedge iCLK); #1;
      iRST = 1'b1;
      idle();
      check("post_arst_state", 32'(oState), 32'(ST_IDLE));
      check("post_arst_rows", 32'(oRows), 32'd0);

      idle();
      check("sb_empty", 32'(exp_q.size()), 32'd0);

      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule
